// File: rtl/bg_tile_fetcher.sv
// PPU background tile fetcher: owns v, runs the 8-dot NT/AT/PT fetch slot and hands one tile per slot to the shifter.
// Optional BG_FETCH_DUMMY_NT_EN: issue the dummy nametable reads on dots 337 and 339 for mapper address snooping.
module bg_tile_fetcher (
  input  logic        clock,
  input  logic        reset,
  input  logic        clock_EN,
  input  logic        renderEnable,
  input  logic [8:0]  dot,
  input  logic [8:0]  scanline,
  input  logic [14:0] tAddr,
  input  logic        copyAll,
  input  logic        bgTableSel,
  output logic [13:0] vramAddr,
  output logic        vramRead,
  input  logic [7:0]  vramData,
  output logic [14:0] vAddr,
  output logic [7:0]  tileLowByte,
  output logic [7:0]  tileHighByte,
  output logic [1:0]  tileAttr,
  output logic        loadOut
);

  logic [7:0]  nt_byte;
  logic [7:0]  pt_low;
  logic [1:0]  attr_bits;
  logic [1:0]  attr_quad;
  logic        slot_valid;
  logic [14:0] next_v;
  logic        fetch_line;
  logic        fetch_dot;
  logic        fetching;
  logic [2:0]  phase;
  logic [13:0] nt_addr;
  logic [13:0] at_addr;
  logic [13:0] pt_addr_lo;
  logic [13:0] pt_addr_hi;

  function automatic logic [14:0] inc_coarse_x(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[4:0] == 5'd31) begin
      r[4:0] = 5'd0;
      r[10]  = ~v[10];
    end else begin
      r[4:0] = v[4:0] + 5'd1;
    end
    return r;
  endfunction

  // Coarse Y rows 30/31 hold attribute data; wrapping from 31 must not switch nametables.
  function automatic logic [14:0] inc_y(input logic [14:0] v);
    logic [14:0] r;
    r = v;
    if (v[14:12] != 3'd7) begin
      r[14:12] = v[14:12] + 3'd1;
    end else begin
      r[14:12] = 3'd0;
      if (v[9:5] == 5'd29) begin
        r[9:5] = 5'd0;
        r[11]  = ~v[11];
      end else if (v[9:5] == 5'd31) begin
        r[9:5] = 5'd0;
      end else begin
        r[9:5] = v[9:5] + 5'd1;
      end
    end
    return r;
  endfunction

  assign fetch_line = (scanline <= 9'd239) || (scanline == 9'd261);
  assign fetch_dot  = fetch_line && (((dot >= 9'd1) && (dot <= 9'd256)) ||
                                     ((dot >= 9'd321) && (dot <= 9'd336)));
  assign fetching   = renderEnable && fetch_dot;
  assign phase      = dot[2:0];

  assign nt_addr    = {2'b10, vAddr[11:0]};
  assign at_addr    = {2'b10, vAddr[11:10], 4'b1111, vAddr[9:7], vAddr[4:2]};
  assign pt_addr_lo = {1'b0, bgTableSel, nt_byte, 1'b0, vAddr[14:12]};
  assign pt_addr_hi = {1'b0, bgTableSel, nt_byte, 1'b1, vAddr[14:12]};

  always_comb begin
    next_v = vAddr;
    if (fetching && (phase == 3'd0))
      next_v = inc_coarse_x(next_v);
    if (renderEnable && fetch_line && (dot == 9'd256))
      next_v = inc_y(next_v);
    if (renderEnable && fetch_line && (dot == 9'd257)) begin
      next_v[10]  = tAddr[10];
      next_v[4:0] = tAddr[4:0];
    end
    if (renderEnable && (scanline == 9'd261) && (dot >= 9'd280) && (dot <= 9'd304)) begin
      next_v[14:11] = tAddr[14:11];
      next_v[9:5]   = tAddr[9:5];
    end
    if (copyAll)
      next_v = tAddr;
  end

  // slot_valid marks a slot that began with its phase-1 read; a slot interrupted by a gap in rendering never loads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vAddr        <= 15'd0;
      vramAddr     <= 14'd0;
      vramRead     <= 1'b0;
      tileLowByte  <= 8'd0;
      tileHighByte <= 8'd0;
      tileAttr     <= 2'd0;
      loadOut      <= 1'b0;
      nt_byte      <= 8'd0;
      pt_low       <= 8'd0;
      attr_bits    <= 2'd0;
      attr_quad    <= 2'd0;
      slot_valid   <= 1'b0;
    end else if (clock_EN) begin
      vAddr    <= next_v;
      vramRead <= 1'b0;
      loadOut  <= 1'b0;
      if (!fetching) begin
        slot_valid <= 1'b0;
      end else begin
        case (phase)
          3'd1: begin
            slot_valid <= 1'b1;
            vramRead   <= 1'b1;
            vramAddr   <= nt_addr;
          end
          3'd2: if (slot_valid) nt_byte <= vramData;
          3'd3: if (slot_valid) begin
            vramRead  <= 1'b1;
            vramAddr  <= at_addr;
            attr_quad <= {vAddr[6], vAddr[1]};
          end
          3'd4: if (slot_valid) begin
            case (attr_quad)
              2'd0:    attr_bits <= vramData[1:0];
              2'd1:    attr_bits <= vramData[3:2];
              2'd2:    attr_bits <= vramData[5:4];
              default: attr_bits <= vramData[7:6];
            endcase
          end
          3'd5: if (slot_valid) begin
            vramRead <= 1'b1;
            vramAddr <= pt_addr_lo;
          end
          3'd6: if (slot_valid) pt_low <= vramData;
          3'd7: if (slot_valid) begin
            vramRead <= 1'b1;
            vramAddr <= pt_addr_hi;
          end
          default: if (slot_valid) begin
            tileLowByte  <= pt_low;
            tileHighByte <= vramData;
            tileAttr     <= attr_bits;
            loadOut      <= 1'b1;
          end
        endcase
      end
`ifdef BG_FETCH_DUMMY_NT_EN
      if (renderEnable && fetch_line && ((dot == 9'd337) || (dot == 9'd339))) begin
        vramRead <= 1'b1;
        vramAddr <= nt_addr;
      end
`endif
    end
  end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher: v-update vector table plus hand-written fetch-slot sequences.
module tb_bg_tile_fetcher;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clock_EN = 1'b1;
  logic        renderEnable = 1'b1;
  logic [8:0]  dot = 9'd0;
  logic [8:0]  scanline = 9'd0;
  logic [14:0] tAddr = 15'd0;
  logic        copyAll = 1'b0;
  logic        bgTableSel = 1'b0;
  logic [13:0] vramAddr;
  logic        vramRead;
  logic [7:0]  vramData;
  logic [14:0] vAddr;
  logic [7:0]  tileLowByte;
  logic [7:0]  tileHighByte;
  logic [1:0]  tileAttr;
  logic        loadOut;

  logic [7:0] mem [16384];
  int checks = 0;
  int errors = 0;

  assign vramData = mem[vramAddr];

  bg_tile_fetcher dut (
    .clock(clock), .reset(reset), .clock_EN(clock_EN), .renderEnable(renderEnable),
    .dot(dot), .scanline(scanline), .tAddr(tAddr), .copyAll(copyAll),
    .bgTableSel(bgTableSel), .vramAddr(vramAddr), .vramRead(vramRead),
    .vramData(vramData), .vAddr(vAddr), .tileLowByte(tileLowByte),
    .tileHighByte(tileHighByte), .tileAttr(tileAttr), .loadOut(loadOut)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [14:0] v0;
    logic [14:0] tAddr;
    logic [8:0]  dotV;
    logic [8:0]  line;
    logic        re;
    logic        copy;
    logic [14:0] expV;
  } vec_t;

  vec_t vec [18];

  task automatic applyStimulus(input logic [8:0] d, input logic [8:0] s);
    dot = d;
    scanline = s;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic loadV(input logic [14:0] v, input logic [8:0] d, input logic [8:0] s);
    tAddr = v;
    copyAll = 1'b1;
    applyStimulus(d, s);
    copyAll = 1'b0;
  endtask

  initial begin
    int loads;
    logic expDummy;

    for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[14'h2000] = 8'h42;
    mem[14'h23C0] = 8'hE4;
    mem[14'h0420] = 8'hAA;
    mem[14'h0428] = 8'h55;
    mem[14'h2042] = 8'h07;
    mem[14'h1070] = 8'h3C;
    mem[14'h1078] = 8'hC3;

    //            v0        tAddr     dot      line      re    copy  expV
    vec[0]  = '{15'h0000, 15'h0000, 9'd8,   9'd0,   1'b1, 1'b0, 15'h0001};
    vec[1]  = '{15'h001F, 15'h0000, 9'd8,   9'd0,   1'b1, 1'b0, 15'h0400};
    vec[2]  = '{15'h041F, 15'h0000, 9'd8,   9'd0,   1'b1, 1'b0, 15'h0000};
    vec[3]  = '{15'h73A5, 15'h0000, 9'd256, 9'd0,   1'b1, 1'b0, 15'h0806};
    vec[4]  = '{15'h73E0, 15'h0000, 9'd256, 9'd0,   1'b1, 1'b0, 15'h0001};
    vec[5]  = '{15'h315F, 15'h0000, 9'd256, 9'd0,   1'b1, 1'b0, 15'h4540};
    vec[6]  = '{15'h73C2, 15'h0000, 9'd256, 9'd0,   1'b1, 1'b0, 15'h03E3};
    vec[7]  = '{15'h78A0, 15'h0000, 9'd256, 9'd0,   1'b1, 1'b0, 15'h08C1};
    vec[8]  = '{15'h7FFF, 15'h0000, 9'd257, 9'd0,   1'b1, 1'b0, 15'h7BE0};
    vec[9]  = '{15'h0000, 15'h7BFF, 9'd290, 9'd261, 1'b1, 1'b0, 15'h7BE0};
    vec[10] = '{15'h1234, 15'h7BFF, 9'd290, 9'd100, 1'b1, 1'b0, 15'h1234};
    vec[11] = '{15'h0005, 15'h0000, 9'd8,   9'd0,   1'b0, 1'b0, 15'h0005};
    vec[12] = '{15'h0005, 15'h0000, 9'd8,   9'd240, 1'b1, 1'b0, 15'h0005};
    vec[13] = '{15'h0005, 15'h0000, 9'd328, 9'd261, 1'b1, 1'b0, 15'h0006};
    vec[14] = '{15'h0005, 15'h0000, 9'd320, 9'd0,   1'b1, 1'b0, 15'h0005};
    vec[15] = '{15'h0000, 15'h1234, 9'd16,  9'd0,   1'b1, 1'b1, 15'h1234};
    vec[16] = '{15'h0000, 15'h2ABC, 9'd10,  9'd0,   1'b0, 1'b1, 15'h2ABC};
    vec[17] = '{15'h0000, 15'h041F, 9'd257, 9'd0,   1'b1, 1'b0, 15'h041F};

    // Reset held across a few edges with rendering on.
    for (int d = 1; d <= 4; d++) applyStimulus(9'(d), 9'd0);
    checkOutput("reset vramAddr", 32'(vramAddr), 32'h0);
    checkOutput("reset vramRead", 32'(vramRead), 32'h0);
    checkOutput("reset vAddr", 32'(vAddr), 32'h0);
    checkOutput("reset tileLowByte", 32'(tileLowByte), 32'h0);
    checkOutput("reset tileHighByte", 32'(tileHighByte), 32'h0);
    checkOutput("reset tileAttr", 32'(tileAttr), 32'h0);
    checkOutput("reset loadOut", 32'(loadOut), 32'h0);
    reset = 1'b0;

    // First tile after reset release.
    applyStimulus(9'd0, 9'd0);
    checkOutput("dot0 vramRead", 32'(vramRead), 32'h0);
    applyStimulus(9'd1, 9'd0);
    checkOutput("dot1 vramRead", 32'(vramRead), 32'h1);
    checkOutput("dot1 NT addr", 32'(vramAddr), 32'h2000);
    applyStimulus(9'd2, 9'd0);
    checkOutput("dot2 vramRead", 32'(vramRead), 32'h0);
    applyStimulus(9'd3, 9'd0);
    checkOutput("dot3 AT addr", 32'(vramAddr), 32'h23C0);
    applyStimulus(9'd4, 9'd0);
    applyStimulus(9'd5, 9'd0);
    checkOutput("dot5 PT low addr", 32'(vramAddr), 32'h0420);
    applyStimulus(9'd6, 9'd0);
    applyStimulus(9'd7, 9'd0);
    checkOutput("dot7 PT high addr", 32'(vramAddr), 32'h0428);
    checkOutput("dot7 loadOut", 32'(loadOut), 32'h0);
    applyStimulus(9'd8, 9'd0);
    checkOutput("dot8 loadOut", 32'(loadOut), 32'h1);
    checkOutput("dot8 tileLowByte", 32'(tileLowByte), 32'hAA);
    checkOutput("dot8 tileHighByte", 32'(tileHighByte), 32'h55);
    checkOutput("dot8 tileAttr", 32'(tileAttr), 32'h0);
    checkOutput("dot8 vAddr", 32'(vAddr), 32'h0001);
    applyStimulus(9'd9, 9'd0);
    checkOutput("dot9 loadOut", 32'(loadOut), 32'h0);
    checkOutput("dot9 NT addr", 32'(vramAddr), 32'h2001);

    // Asynchronous reset mid-slot, then the restart waits for the next phase 1.
    reset = 1'b1;
    #1;
    checkOutput("async reset vramRead", 32'(vramRead), 32'h0);
    checkOutput("async reset vAddr", 32'(vAddr), 32'h0);
    checkOutput("async reset tileLowByte", 32'(tileLowByte), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    applyStimulus(9'd11, 9'd0);
    checkOutput("post-reset dot11 vramRead", 32'(vramRead), 32'h0);
    for (int d = 12; d <= 15; d++) applyStimulus(9'(d), 9'd0);
    applyStimulus(9'd16, 9'd0);
    checkOutput("post-reset dot16 loadOut", 32'(loadOut), 32'h0);

    // Second tile: upper pattern table, bottom-right attribute quadrant.
    bgTableSel = 1'b1;
    loadV(15'h0042, 9'd0, 9'd0);
    for (int d = 1; d <= 8; d++) applyStimulus(9'(d), 9'd0);
    checkOutput("tile2 loadOut", 32'(loadOut), 32'h1);
    checkOutput("tile2 tileLowByte", 32'(tileLowByte), 32'h3C);
    checkOutput("tile2 tileHighByte", 32'(tileHighByte), 32'hC3);
    checkOutput("tile2 tileAttr", 32'(tileAttr), 32'h3);
    checkOutput("tile2 vAddr", 32'(vAddr), 32'h0043);
    bgTableSel = 1'b0;

    // renderEnable dropped at dot 4, re-enabled at dot 9, then a rising edge mid-slot.
    loadV(15'h0000, 9'd0, 9'd0);
    for (int d = 1; d <= 3; d++) applyStimulus(9'(d), 9'd0);
    renderEnable = 1'b0;
    for (int d = 4; d <= 8; d++) begin
      applyStimulus(9'(d), 9'd0);
      checkOutput($sformatf("disabled dot%0d loadOut", d), 32'(loadOut), 32'h0);
      checkOutput($sformatf("disabled dot%0d vramRead", d), 32'(vramRead), 32'h0);
    end
    checkOutput("disabled vAddr held", 32'(vAddr), 32'h0);
    checkOutput("disabled tileLowByte held", 32'(tileLowByte), 32'h3C);
    renderEnable = 1'b1;
    applyStimulus(9'd9, 9'd0);
    checkOutput("reenable dot9 vramRead", 32'(vramRead), 32'h1);
    checkOutput("reenable dot9 addr", 32'(vramAddr), 32'h2000);
    renderEnable = 1'b0;
    applyStimulus(9'd10, 9'd0);
    renderEnable = 1'b1;
    applyStimulus(9'd11, 9'd0);
    checkOutput("mid-slot rise dot11 vramRead", 32'(vramRead), 32'h0);
    for (int d = 12; d <= 15; d++) applyStimulus(9'(d), 9'd0);
    applyStimulus(9'd16, 9'd0);
    checkOutput("mid-slot rise dot16 loadOut", 32'(loadOut), 32'h0);

    // Pre-render vertical copy sweep over dots 280-304.
    loadV(15'h0000, 9'd279, 9'd261);
    tAddr = 15'h7BFF;
    for (int d = 280; d <= 304; d++) applyStimulus(9'(d), 9'd261);
    checkOutput("vertical copy vAddr", 32'(vAddr), 32'h7BE0);

    // Next-line prefetch: two tiles over dots 321-336, dummy NT reads only when configured.
`ifdef BG_FETCH_DUMMY_NT_EN
    expDummy = 1'b1;
`else
    expDummy = 1'b0;
`endif
    loadV(15'h0000, 9'd320, 9'd261);
    loads = 0;
    for (int d = 321; d <= 340; d++) begin
      applyStimulus(9'(d), 9'd261);
      if (loadOut) loads++;
      if (d == 337 || d == 339) begin
        checkOutput($sformatf("dot%0d dummy vramRead", d), 32'(vramRead), 32'(expDummy));
        checkOutput($sformatf("dot%0d loadOut", d), 32'(loadOut), 32'h0);
      end
    end
    checkOutput("prefetch load count", 32'(loads), 32'd2);
    checkOutput("prefetch vAddr", 32'(vAddr), 32'h0002);

    // No state advance without clock_EN.
    clock_EN = 1'b0;
    applyStimulus(9'd8, 9'd0);
    checkOutput("clock_EN low vAddr", 32'(vAddr), 32'h0002);
    clock_EN = 1'b1;

    // v-update vector table.
    for (int i = 0; i < 18; i++) begin
      renderEnable = 1'b1;
      loadV(vec[i].v0, 9'd0, 9'd0);
      copyAll = vec[i].copy;
      tAddr = vec[i].tAddr;
      renderEnable = vec[i].re;
      applyStimulus(vec[i].dotV, vec[i].line);
      copyAll = 1'b0;
      checkOutput($sformatf("vec%0d vAddr", i), 32'(vAddr), 32'(vec[i].expV));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
